// File: rtl/straight_gen.sv
// straight_gen: valid/retry producer emitting base, base+stride, ... for a
// programmed number of tokens after a one-cycle start command.
// Optional build macro STRAIGHT_GEN_BUBBLE_EN inserts LFSR-driven bubble
// cycles between tokens; the port list is identical in both builds.
module straight_gen #(
   parameter int Size      = 8,
   parameter int CountBits = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 start,
   input  logic [Size-1:0]      cfg_base,
   input  logic [Size-1:0]      cfg_stride,
   input  logic [CountBits-1:0] cfg_count,
   output logic [Size-1:0]      dout,
   output logic                 doutValid,
   input  logic                 doutRetry,
   output logic                 busy,
   output logic                 done,
   output logic [CountBits-1:0] sent
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CountBits-1:0] CntOne = CountBits'(1);

   state_t               state;
   logic [Size-1:0]      stride;
   logic [CountBits-1:0] remaining;
   logic                 xfer;
   logic                 nextValid;

   assign xfer = doutValid & ~doutRetry;
   assign busy = (state == RUN);

`ifdef STRAIGHT_GEN_BUBBLE_EN
   logic [15:0] lfsr;
   logic        lfsrFb;

   assign lfsrFb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) picking bubble cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsrFb, lfsr[15:1]};
   end

   // A transfer with lfsr[0] set leaves one idle cycle before the next token
   assign nextValid = ~lfsr[0];
`else
   assign nextValid = 1'b1;
`endif

   // Sequencer: start latch, token advance on transfer, one-cycle done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dout      <= '0;
         doutValid <= 1'b0;
         done      <= 1'b0;
         sent      <= '0;
         stride    <= '0;
         remaining <= '0;
      end else if (clear) begin
         // clear wins over start and over a same-cycle transfer; sent is kept
         state     <= IDLE;
         doutValid <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dout      <= cfg_base;
                  stride    <= cfg_stride;
                  remaining <= cfg_count;
                  sent      <= '0;
                  if (cfg_count != '0) begin
                     state     <= RUN;
                     doutValid <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (xfer) begin
                  if (sent != '1) sent <= sent + CntOne;
                  remaining <= remaining - CntOne;
                  if (remaining == CntOne) begin
                     // last token keeps its value on dout after completion
                     state     <= DONE;
                     done      <= 1'b1;
                     doutValid <= 1'b0;
                  end else begin
                     dout      <= dout + stride;
                     doutValid <= nextValid;
                  end
               end else if (!doutValid) begin
                  // bubble cycle ends; present the pending token
                  doutValid <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               doutValid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_straight_gen.sv
// tb_straight_gen: directed self-checking bench for straight_gen.
module tb_straight_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       start;
   logic [7:0] cfg_base;
   logic [7:0] cfg_stride;
   logic [7:0] cfg_count;
   logic [7:0] dout;
   logic       doutValid;
   logic       doutRetry;
   logic       busy;
   logic       done;
   logic [7:0] sent;

   int tests = 0;
   int fails = 0;

   straight_gen #(.Size(8), .CountBits(8)) dut (
      .clk(clk), .reset(reset), .clear(clear), .start(start),
      .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
      .dout(dout), .doutValid(doutValid), .doutRetry(doutRetry),
      .busy(busy), .done(done), .sent(sent)
   );

   always #5 clk = ~clk;

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue a one-cycle start; returns positioned in cycle N+1 with start low
   task automatic do_start(input logic [7:0] b, input logic [7:0] s, input logic [7:0] c);
      start = 1'b1; cfg_base = b; cfg_stride = s; cfg_count = c;
      tick();
      start = 1'b0; cfg_base = 8'hxx; cfg_stride = 8'hxx; cfg_count = 8'hxx;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; start = 1'b0; doutRetry = 1'b0;
      cfg_base = '0; cfg_stride = '0; cfg_count = '0;
      tick(); tick();
      tests++;
      if ({dout, doutValid, busy, done, sent} !== 19'd0) begin
         fails++;
         $display("FAIL reset_outputs got dout=%h v=%b busy=%b done=%b sent=%0d want all 0",
                  dout, doutValid, busy, done, sent);
      end
      @(negedge clk); reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] expD [4];
      expD = '{8'h10, 8'h13, 8'h16, 8'h19};
      do_start(8'h10, 8'h03, 8'd4);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (doutValid !== 1'b1 || dout !== expD[i] || busy !== 1'b1 || sent !== 8'(i) || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_tok%0d got v=%b d=%h busy=%b sent=%0d done=%b want v=1 d=%h busy=1 sent=%0d done=0",
                     i, doutValid, dout, busy, sent, done, expD[i], i);
         end
         tick();
      end
      tests++;
      if (done !== 1'b1 || doutValid !== 1'b0 || busy !== 1'b0 || sent !== 8'd4) begin
         fails++;
         $display("FAIL basic_done got done=%b v=%b busy=%b sent=%0d want done=1 v=0 busy=0 sent=4",
                  done, doutValid, busy, sent);
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL basic_done_pulse got done=%b want 0", done);
      end
   endtask

   task automatic test_backpressure();
      logic       rt   [8];
      logic       expV [8];
      logic [7:0] expD [8];
      logic       expDn[8];
      rt    = '{0, 1, 1, 1, 0, 0, 0, 0};
      expV  = '{1, 1, 1, 1, 1, 1, 1, 0};
      expD  = '{8'h10, 8'h13, 8'h13, 8'h13, 8'h13, 8'h16, 8'h19, 8'h19};
      expDn = '{0, 0, 0, 0, 0, 0, 0, 1};
      do_start(8'h10, 8'h03, 8'd4);
      for (int k = 0; k < 8; k++) begin
         doutRetry = rt[k];
         tests++;
         if (doutValid !== expV[k] || done !== expDn[k] || (expV[k] && dout !== expD[k])) begin
            fails++;
            $display("FAIL backpressure_cyc%0d got v=%b d=%h done=%b want v=%b d=%h done=%b",
                     k + 1, doutValid, dout, done, expV[k], expD[k], expDn[k]);
         end
         tick();
      end
      doutRetry = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] expA [3];
      logic [7:0] expB [3];
      expA = '{8'hFE, 8'hFF, 8'h00};
      expB = '{8'h00, 8'h80, 8'h00};
      do_start(8'hFE, 8'h01, 8'd3);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (doutValid !== 1'b1 || dout !== expA[i]) begin
            fails++;
            $display("FAIL wrapA_tok%0d got v=%b d=%h want v=1 d=%h", i, doutValid, dout, expA[i]);
         end
         tick();
      end
      tests++;
      if (done !== 1'b1 || sent !== 8'd3) begin
         fails++;
         $display("FAIL wrapA_done got done=%b sent=%0d want done=1 sent=3", done, sent);
      end
      tick();
      do_start(8'h00, 8'h80, 8'd3);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (doutValid !== 1'b1 || dout !== expB[i]) begin
            fails++;
            $display("FAIL wrapB_tok%0d got v=%b d=%h want v=1 d=%h", i, doutValid, dout, expB[i]);
         end
         tick();
      end
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL wrapB_done got done=%b want 1", done);
      end
      tick();
   endtask

   task automatic test_zero_and_ignored_start();
      logic [7:0] expD [4];
      expD = '{8'h10, 8'h13, 8'h16, 8'h19};
      do_start(8'h77, 8'h01, 8'd0);
      tests++;
      if (doutValid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || sent !== 8'd0) begin
         fails++;
         $display("FAIL zero_count got v=%b done=%b busy=%b sent=%0d want v=0 done=1 busy=0 sent=0",
                  doutValid, done, busy, sent);
      end
      tick();
      tests++;
      if (doutValid !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL zero_count_after got v=%b done=%b want v=0 done=0", doutValid, done);
      end
      do_start(8'h10, 8'h03, 8'd4);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            start = 1'b1; cfg_base = 8'h55; cfg_stride = 8'h01; cfg_count = 8'd9;
         end else begin
            start = 1'b0;
         end
         tests++;
         if (doutValid !== 1'b1 || dout !== expD[i]) begin
            fails++;
            $display("FAIL ignored_start_tok%0d got v=%b d=%h want v=1 d=%h", i, doutValid, dout, expD[i]);
         end
         tick();
      end
      start = 1'b0;
      tests++;
      if (done !== 1'b1 || sent !== 8'd4 || busy !== 1'b0) begin
         fails++;
         $display("FAIL ignored_start_done got done=%b sent=%0d busy=%b want done=1 sent=4 busy=0",
                  done, sent, busy);
      end
      tick();
   endtask

   task automatic test_abort();
      do_start(8'h20, 8'h01, 8'd5);
      tick();
      tests++;
      if (doutValid !== 1'b1 || dout !== 8'h21) begin
         fails++;
         $display("FAIL abort_tok1 got v=%b d=%h want v=1 d=21", doutValid, dout);
      end
      tick();
      clear = 1'b1;
      tests++;
      if (doutValid !== 1'b1 || dout !== 8'h22 || sent !== 8'd2) begin
         fails++;
         $display("FAIL abort_tok2 got v=%b d=%h sent=%0d want v=1 d=22 sent=2", doutValid, dout, sent);
      end
      tick();
      clear = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (doutValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent !== 8'd2) begin
            fails++;
            $display("FAIL abort_after%0d got v=%b busy=%b done=%b sent=%0d want v=0 busy=0 done=0 sent=2",
                     k, doutValid, busy, done, sent);
         end
         tick();
      end
      do_start(8'h40, 8'h02, 8'd2);
      tests++;
      if (doutValid !== 1'b1 || dout !== 8'h40 || sent !== 8'd0) begin
         fails++;
         $display("FAIL abort_restart0 got v=%b d=%h sent=%0d want v=1 d=40 sent=0", doutValid, dout, sent);
      end
      tick();
      tests++;
      if (doutValid !== 1'b1 || dout !== 8'h42) begin
         fails++;
         $display("FAIL abort_restart1 got v=%b d=%h want v=1 d=42", doutValid, dout);
      end
      tick();
      tests++;
      if (done !== 1'b1 || sent !== 8'd2) begin
         fails++;
         $display("FAIL abort_restart_done got done=%b sent=%0d want done=1 sent=2", done, sent);
      end
      tick();
   endtask

   task automatic test_async_reset();
      doutRetry = 1'b1;
      do_start(8'h10, 8'h03, 8'd4);
      tick();
      tests++;
      if (doutValid !== 1'b1 || dout !== 8'h10 || busy !== 1'b1) begin
         fails++;
         $display("FAIL areset_pre got v=%b d=%h busy=%b want v=1 d=10 busy=1", doutValid, dout, busy);
      end
      #3 reset = 1'b1;
      #1;
      tests++;
      if ({dout, doutValid, busy, done, sent} !== 19'd0) begin
         fails++;
         $display("FAIL areset_immediate got dout=%h v=%b busy=%b done=%b sent=%0d want all 0",
                  dout, doutValid, busy, done, sent);
      end
`ifdef STRAIGHT_GEN_BUBBLE_EN
      tests++;
      if (dut.lfsr !== 16'hACE1) begin
         fails++;
         $display("FAIL areset_lfsr got %h want ace1", dut.lfsr);
      end
`endif
      @(negedge clk);
      reset = 1'b0; doutRetry = 1'b0;
      tick();
      tests++;
      if (doutValid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL areset_idle got v=%b busy=%b want v=0 busy=0", doutValid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_and_ignored_start();
      test_abort();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
